// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, odd-parity helper and
// the command/response bytes used by the keyboard host logic.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      RELEASE_WAIT
   } txState_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   // Named RSP_ACK because ACK is taken by the state enum.
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   function automatic logic oddParity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser with falling-edge detect for asynchronous PS/2 pad
// levels; shared by the host transmitter and the keyboard receiver.
module ps2_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] asyncIn,
   output logic [WIDTH-1:0] syncOut,
   output logic [WIDTH-1:0] fallOut
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q <= '1;
         sync_q <= '1;
         prev_q <= '1;
      end else begin
         meta_q <= asyncIn;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign syncOut = sync_q;
   assign fallOut = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge shift, ack.
// Optional watchdog on the device-clocked phase enabled by PS2_TX_TIMEOUT_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   input  logic       ps2ClkIn,
   input  logic       ps2DataIn,
   output logic       ps2ClkOe,
   output logic       ps2DataOe,
   output logic       txDone,
   output logic       txError,
   output logic       busy
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   txState_e         state_q, state_d;
   logic [INH_W-1:0] inhCnt_q, inhCnt_d;
   logic [3:0]       bitCnt_q, bitCnt_d;
   logic [8:0]       frame_q, frame_d;
   logic             dataOe_q, dataOe_d;
   logic             inhibitLast;
   logic             clkOe;

   logic [1:0]       lineSync;
   logic [1:0]       lineFall;
   logic             clkFall;
   logic             unusedDataFall;

   ps2_sync_edge #(
      .WIDTH (2)
   ) uSync (
      .clock   (clock),
      .reset   (reset),
      .asyncIn ({ps2DataIn, ps2ClkIn}),
      .syncOut (lineSync),
      .fallOut (lineFall)
   );

   assign clkFall        = lineFall[0];
   assign unusedDataFall = lineFall[1];

`ifdef PS2_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] toCnt_q, toCnt_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         toCnt_q <= '0;
      end else begin
         toCnt_q <= toCnt_d;
      end
   end
`else
   localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         inhCnt_q <= '0;
         bitCnt_q <= '0;
         frame_q  <= '0;
         dataOe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         inhCnt_q <= inhCnt_d;
         bitCnt_q <= bitCnt_d;
         frame_q  <= frame_d;
         dataOe_q <= dataOe_d;
      end
   end

   // frame_q holds {parity, d7..d0}; bitCnt_q counts device falling edges seen.
   always_comb begin
      state_d     = state_q;
      inhCnt_d    = inhCnt_q;
      bitCnt_d    = bitCnt_q;
      frame_d     = frame_q;
      dataOe_d    = dataOe_q;
      inhibitLast = 1'b0;
      clkOe       = 1'b0;
      txDone      = 1'b0;
      txError     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      toCnt_d     = toCnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (txValid) begin
               frame_d = {oddParity(txData), txData};
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            clkOe = 1'b1;
            if (inhCnt_q == INH_LAST) begin
               inhibitLast = 1'b1;
               dataOe_d    = 1'b1;
               state_d     = REQ;
            end else begin
               inhCnt_d = inhCnt_q + INH_W'(1);
            end
         end
         REQ: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            if (clkFall) begin
               bitCnt_d = bitCnt_q + 4'd1;
               if (bitCnt_q <= 4'd8) begin
                  dataOe_d = ~frame_q[bitCnt_q];
               end else begin
                  dataOe_d = 1'b0;
                  state_d  = ACK;
               end
            end
         end
         ACK: begin
            if (clkFall) begin
               if (bitCnt_q != 4'd10) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end
               if (lineSync[1]) begin
                  txError = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RELEASE_WAIT;
               end
            end
         end
         RELEASE_WAIT: begin
            if (&lineSync) begin
               txDone  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog runs from the REQ cycle onward so it measures from line release.
      if (state_q == IDLE || state_q == INHIBIT) begin
         toCnt_d = '0;
      end else if (toCnt_q != TO_MAX) begin
         toCnt_d = toCnt_q + TO_W'(1);
      end
      if ((state_q == SHIFT || state_q == ACK || state_q == RELEASE_WAIT) &&
          toCnt_q == TO_MAX) begin
         txDone  = 1'b0;
         txError = 1'b1;
         state_d = IDLE;
      end
`endif

      if (state_d == IDLE) begin
         bitCnt_d = '0;
         inhCnt_d = '0;
         dataOe_d = 1'b0;
      end
   end

   assign ps2ClkOe  = clkOe;
   assign ps2DataOe = dataOe_q | inhibitLast;
   assign txReady   = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model; covers
// ack/nack frames, parity, mid-frame reset, held txValid and the stall/timeout.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int TO   = 3000;
   localparam int HALF = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       txReady;
   logic       ps2ClkIn;
   logic       ps2DataIn;
   logic       ps2ClkOe;
   logic       ps2DataOe;
   logic       txDone;
   logic       txError;
   logic       busy;
   logic       devClk = 1'b1;
   logic       devData = 1'b1;

   int compared = 0;
   int mismatched = 0;
   int doneCount = 0;
   int errCount = 0;
   int bothCount = 0;
   int startCount = 0;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .txData    (txData),
      .txValid   (txValid),
      .txReady   (txReady),
      .ps2ClkIn  (ps2ClkIn),
      .ps2DataIn (ps2DataIn),
      .ps2ClkOe  (ps2ClkOe),
      .ps2DataOe (ps2DataOe),
      .txDone    (txDone),
      .txError   (txError),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Wired-AND pad model: either side pulling low wins.
   assign ps2ClkIn  = devClk & ~ps2ClkOe;
   assign ps2DataIn = devData & ~ps2DataOe;

   always @(negedge clock) begin
      if (reset) begin
         doneCount = doneCount + int'(txDone);
         errCount  = errCount + int'(txError);
         if (txDone && txError) bothCount = bothCount + 1;
      end
   end

   always @(posedge ps2ClkOe) startCount = startCount + 1;

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // Requests one frame and plays the device side; abortEdge>0 stops after that edge.
   task automatic applyStimulus(input logic [7:0] data, input logic ackLevel,
                                input int abortEdge, input logic holdValid,
                                input logic [7:0] nextData,
                                output logic [7:0] gotData, output logic gotParity,
                                output logic gotStart, output logic gotStop,
                                output int inhCycles);
      logic [9:0] bits;
      int guard;
      bits      = '0;
      gotData   = '0;
      gotParity = 1'b0;
      gotStart  = 1'b1;
      gotStop   = 1'b0;
      inhCycles = 0;
      txData    = data;
      txValid   = 1'b1;
      guard     = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (!ps2ClkOe && guard < 200);
      if (!ps2ClkOe) begin
         checkOutput("requestSeen", 32'(ps2ClkOe), 32'd1);
         txValid = 1'b0;
         return;
      end
      if (holdValid) txData = nextData;
      else txValid = 1'b0;
      inhCycles = 1;
      while (1) begin
         @(negedge clock);
         if (!ps2ClkOe || inhCycles > 10000) break;
         inhCycles++;
      end
      repeat (HALF) @(negedge clock);
      gotStart = ps2DataIn;
      for (int i = 0; i < 10; i++) begin
         devClk = 1'b0;
         repeat (HALF) @(negedge clock);
         bits[i] = ps2DataIn;
         if (abortEdge == i + 1) begin
            gotData = bits[7:0];
            return;
         end
         devClk = 1'b1;
         repeat (HALF) @(negedge clock);
      end
      gotData   = bits[7:0];
      gotParity = bits[8];
      gotStop   = bits[9];
      devData   = ackLevel;
      repeat (2) @(negedge clock);
      devClk = 1'b0;
      repeat (HALF) @(negedge clock);
      devClk  = 1'b1;
      devData = 1'b1;
      guard   = 0;
      while (busy && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (busy) checkOutput("frameEndTimeout", 32'(busy), 32'd0);
   endtask

   logic [7:0] gData;
   logic       gPar, gStart, gStop;
   int         gInh;
   int         d0, e0, s0, n;

   initial begin
      repeat (3) @(negedge clock);
      checkOutput("resetState", {26'd0, txReady, busy, ps2ClkOe, ps2DataOe, txDone, txError},
                  32'b100000);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("idleAfterReset", {28'd0, txReady, busy, ps2ClkOe, ps2DataOe}, 32'b1000);

      // Set-LEDs command, acked
      d0 = doneCount; e0 = errCount;
      applyStimulus(CMD_SET_LEDS, 1'b0, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("edInhibitLen", gInh, INH);
      checkOutput("edStart", 32'(gStart), 32'd0);
      checkOutput("edData", 32'(gData), 32'hED);
      checkOutput("edParity", 32'(gPar), 32'd1);
      checkOutput("edStop", 32'(gStop), 32'd1);
      checkOutput("edDone", doneCount - d0, 1);
      checkOutput("edNoError", errCount - e0, 0);
      checkOutput("edBusyClear", 32'(busy), 32'd0);

      // Parity boundaries
      d0 = doneCount;
      applyStimulus(8'h00, 1'b0, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("zeroData", 32'(gData), 32'h00);
      checkOutput("zeroParity", 32'(gPar), 32'd1);
      checkOutput("zeroDone", doneCount - d0, 1);
      d0 = doneCount;
      applyStimulus(8'h01, 1'b0, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("oneData", 32'(gData), 32'h01);
      checkOutput("oneParity", 32'(gPar), 32'd0);
      checkOutput("oneDone", doneCount - d0, 1);

      // Device refuses: data high at edge 11
      d0 = doneCount; e0 = errCount;
      applyStimulus(8'h3C, 1'b1, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      @(negedge clock);
      checkOutput("nackError", errCount - e0, 1);
      checkOutput("nackNoDone", doneCount - d0, 0);
      checkOutput("nackLines", {30'd0, ps2ClkOe, ps2DataOe}, 32'd0);
      checkOutput("nackReady", 32'(txReady), 32'd1);

      // Reset while bit d4 (a zero in 8'hED) is being driven
      d0 = doneCount; e0 = errCount;
      applyStimulus(CMD_SET_LEDS, 1'b0, 5, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("abortDataOeBefore", 32'(ps2DataOe), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abortReleased", {28'd0, ps2ClkOe, ps2DataOe, txReady, busy}, 32'b0010);
      devClk = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abortNoPulses", (doneCount - d0) + (errCount - e0), 0);

      d0 = doneCount;
      applyStimulus(CMD_RESET, 1'b0, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("ffData", 32'(gData), 32'hFF);
      checkOutput("ffParity", 32'(gPar), 32'd1);
      checkOutput("ffDone", doneCount - d0, 1);

      // txValid kept high with new data during the frame
      s0 = startCount; d0 = doneCount;
      applyStimulus(8'h55, 1'b0, 0, 1'b1, 8'hAA, gData, gPar, gStart, gStop, gInh);
      checkOutput("holdFirstData", 32'(gData), 32'h55);
      checkOutput("holdSingleStart", startCount - s0, 1);
      applyStimulus(8'hAA, 1'b0, 0, 1'b0, 8'h00, gData, gPar, gStart, gStop, gInh);
      checkOutput("holdSecondInhibit", gInh, INH);
      checkOutput("holdSecondData", 32'(gData), 32'hAA);
      checkOutput("holdSecondParity", 32'(gPar), 32'd1);
      checkOutput("holdDones", doneCount - d0, 2);

      // Silent device: never clocks after request-to-send
      txData  = 8'h12;
      txValid = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!ps2ClkOe && n < 200);
      txValid = 1'b0;
      n = 0;
      while (ps2ClkOe && n < 200) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      while (!txError && n < TO + 200) begin
         @(negedge clock);
         n++;
      end
`ifdef PS2_TX_TIMEOUT_EN
      checkOutput("timeoutLatency", 32'(n >= TO - 2 && n <= TO + 2), 32'd1);
      @(negedge clock);
      checkOutput("timeoutLines", {29'd0, ps2ClkOe, ps2DataOe, txReady}, 32'b001);
`else
      checkOutput("stallNoError", 32'(txError), 32'd0);
      checkOutput("stallBusy", {30'd0, busy, ps2DataOe}, 32'b11);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("stallRecovered", 32'(txReady), 32'd1);
`endif

      checkOutput("neverBothPulses", bothCount, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
